// File: rtl/boot_loader_pkg.sv
// -----------------------------------------------------------------------------
// boot_loader_pkg
// Shared definitions for the serial program loader: 8N1 frame constants,
// state encodings for the UART receiver and the load FSM, and a small
// helper that drops a byte into one lane of a 32-bit word.
// -----------------------------------------------------------------------------
package boot_loader_pkg;

  // 8N1 framing
  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

  // Program memory is written one 32-bit word (4 byte lanes) at a time
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_HDR_LO,
    ST_HDR_HI,
    ST_PAYLOAD,
    ST_DONE,
    ST_ERROR
  } load_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // Replace byte lane 'lane' of 'word' with 'b' (lane 0 = bits 7:0).
  function automatic logic [31:0] put_lane(input logic [31:0] word,
                                           input logic [1:0]  lane,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    r[int'(lane)*8 +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/boot_loader_if.sv
// -----------------------------------------------------------------------------
// boot_loader_if
// Program-memory write port bundle driven by the loader.
//   pmem_wr_addr    word address of the write
//   pmem_ram_in     32-bit instruction word
//   pmem_byte_w_en  byte enables, 4'b1111 during the single write cycle
// Modports: master (loader side, drives), slave (BRAM side, receives).
// -----------------------------------------------------------------------------
interface boot_loader_if #(
  parameter int ADDR_WIDTH = 12
) ();

  logic [ADDR_WIDTH-1:0] pmem_wr_addr;
  logic [31:0]           pmem_ram_in;
  logic [3:0]            pmem_byte_w_en;

  modport master (
    output pmem_wr_addr,
    output pmem_ram_in,
    output pmem_byte_w_en
  );

  modport slave (
    input pmem_wr_addr,
    input pmem_ram_in,
    input pmem_byte_w_en
  );

endinterface

// File: rtl/boot_loader_uart_rx.sv
// -----------------------------------------------------------------------------
// boot_loader_uart_rx
// 8N1 UART receiver: 2-flop synchronizer, falling-edge start detect with a
// mid-start-bit glitch check, mid-bit sampling of 8 data bits (LSB first)
// and a stop-bit check.
// Ports:
//   sysclk, rst     clock, asynchronous active-low reset
//   rx_line         raw serial input (idle high, asynchronous)
//   rx_byte         last received byte (valid with rx_valid)
//   rx_valid        one-cycle pulse, good frame received
//   rx_ferr         one-cycle pulse, stop bit read as 0
//   rx_start        one-cycle pulse when a start edge is detected
// -----------------------------------------------------------------------------
module boot_loader_uart_rx
  import boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       rx_line,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr,
  output logic       rx_start
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic          sync1_q, sync2_q, prev_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx_line;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    rx_start = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        // Edge rather than level, so a line stuck low after a bad stop bit
        // does not retrigger until it has returned high.
        if (prev_q && !sync2_q) begin
          state_d  = RX_START;
          rx_start = 1'b1;
        end
      end
      RX_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          // Line back high at mid start bit: treat as a glitch.
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == LAST_BIT) begin
            state_d = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        // Return to idle at mid stop bit so a back-to-back start edge
        // half a bit later is still caught.
        if (cnt_q == CNT_FULL) begin
          state_d = RX_IDLE;
          valid_d = sync2_q;
          ferr_d  = !sync2_q;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_byte  = shift_q;
  assign rx_valid = valid_q;
  assign rx_ferr  = ferr_q;

endmodule

// File: rtl/boot_loader.sv
// -----------------------------------------------------------------------------
// boot_loader
// Receives a length-prefixed image over an 8N1 UART, packs bytes
// little-endian into 32-bit words and writes them to program memory at
// addresses 0..N-1. Holds the CPU in reset until the image is complete;
// a malformed stream parks it in reset with error set.
// Ports:
//   sysclk, rst     clock, asynchronous active-low reset
//   uart_rx         serial input, idle high
//   pmem            program-memory write port (boot_loader_if.master)
//   cpu_rst         active-high CPU reset, released when load completes
//   busy            load in progress (first start bit until done/error)
//   done, error     sticky load outcome flags
// -----------------------------------------------------------------------------
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT    = 868,
  parameter int PMEM_ADDR_WIDTH = 12
) (
  input  logic          sysclk,
  input  logic          rst,
  input  logic          uart_rx,
  boot_loader_if.master pmem,
  output logic          cpu_rst,
  output logic          busy,
  output logic          done,
  output logic          error
);

  // 17-bit so a full-capacity image (N == 2^PMEM_ADDR_WIDTH) is representable
  localparam logic [16:0] PMEM_WORDS = 17'(2 ** PMEM_ADDR_WIDTH);
  localparam logic [1:0]  LAST_LANE  = 2'(BYTES_PER_WORD - 1);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_ferr, rx_start;

  boot_loader_uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_rx (
    .sysclk   (sysclk),
    .rst      (rst),
    .rx_line  (uart_rx),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr),
    .rx_start (rx_start)
  );

  load_state_e                state_q, state_d;
  logic [15:0]                n_q, n_d;
  logic [16:0]                word_cnt_q, word_cnt_d;
  logic [1:0]                 byte_idx_q, byte_idx_d;
  logic [31:0]                word_q, word_d;
  logic [PMEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                       wr_en_q, wr_en_d;
  logic                       started_q, started_d;
  logic [15:0]                n_full;

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_HDR_LO;
      n_q        <= '0;
      word_cnt_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      wr_en_q    <= 1'b0;
      started_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_cnt_q <= word_cnt_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      wr_en_q    <= wr_en_d;
      started_q  <= started_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    addr_d     = addr_q;
    wr_en_d    = 1'b0;
    started_d  = started_q | rx_start;
    n_full     = {rx_byte, n_q[7:0]};
    case (state_q)
      ST_HDR_LO: begin
        if (rx_ferr) begin
          state_d = ST_ERROR;
        end else if (rx_valid) begin
          n_d[7:0] = rx_byte;
          state_d  = ST_HDR_HI;
        end
      end
      ST_HDR_HI: begin
        if (rx_ferr) begin
          state_d = ST_ERROR;
        end else if (rx_valid) begin
          n_d[15:8] = rx_byte;
          if (n_full == 16'd0) begin
            state_d = ST_DONE;
          end else if ({1'b0, n_full} > PMEM_WORDS) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        // The counter has already advanced past the word being strobed,
        // so equality with N during the strobe marks the final write.
        if (wr_en_q && (word_cnt_q == {1'b0, n_q})) begin
          state_d = ST_DONE;
        end else if (rx_ferr) begin
          state_d = ST_ERROR;
        end else if (rx_valid) begin
          word_d     = put_lane(word_q, byte_idx_q, rx_byte);
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == LAST_LANE) begin
            wr_en_d    = 1'b1;
            addr_d     = word_cnt_q[PMEM_ADDR_WIDTH-1:0];
            word_cnt_d = word_cnt_q + 17'd1;
          end
        end
      end
      ST_DONE:  state_d = ST_DONE;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase
  end

  assign pmem.pmem_wr_addr   = addr_q;
  assign pmem.pmem_ram_in    = word_q;
  assign pmem.pmem_byte_w_en = {4{wr_en_q}};

  assign done    = (state_q == ST_DONE);
  assign error   = (state_q == ST_ERROR);
  assign cpu_rst = !done;
  assign busy    = started_q && !done && !error;

endmodule

// File: tb/tb_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_boot_loader
// Drives UART byte streams into boot_loader and compares the observed
// program-memory writes and status flags against a stream-level model.
// -----------------------------------------------------------------------------
module tb_boot_loader;

  localparam int CPB   = 4;
  localparam int AW    = 4;
  localparam int WORDS = 16;

  logic sysclk  = 1'b0;
  logic rst     = 1'b0;
  logic uart_rx = 1'b1;
  logic cpu_rst, busy, done, error;

  boot_loader_if #(.ADDR_WIDTH(AW)) pmem_bus ();

  boot_loader #(
    .CLKS_PER_BIT    (CPB),
    .PMEM_ADDR_WIDTH (AW)
  ) dut (
    .sysclk  (sysclk),
    .rst     (rst),
    .uart_rx (uart_rx),
    .pmem    (pmem_bus),
    .cpu_rst (cpu_rst),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  always #5 sysclk = ~sysclk;

  int checks_total  = 0;
  int checks_passed = 0;
  int cyc           = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // ---------------- monitor ----------------
  logic [AW-1:0] mon_addr[$];
  logic [31:0]   mon_data[$];
  int            last_strobe_cyc = -1;
  int            done_rise_cyc   = -1;
  logic          prev_done       = 1'b0;

  always @(posedge sysclk) cyc++;

  always @(negedge sysclk) begin
    if (pmem_bus.pmem_byte_w_en !== 4'h0) begin
      chk("strobe_mask", 64'(pmem_bus.pmem_byte_w_en), 64'hF);
      mon_addr.push_back(pmem_bus.pmem_wr_addr);
      mon_data.push_back(pmem_bus.pmem_ram_in);
      last_strobe_cyc = cyc;
    end
    if (done === 1'b1 && prev_done !== 1'b1) done_rise_cyc = cyc;
    prev_done = done;
  end

  // ---------------- reference model ----------------
  logic [7:0]    sb[$];
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];
  logic          exp_done, exp_err;

  // fe = index of the byte sent with a bad stop bit, -1 for none
  function automatic void build_expect(input int fe);
    int n;
    exp_addr.delete();
    exp_data.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (fe == 0 || fe == 1) begin
      exp_err = 1'b1;
      return;
    end
    n = int'(sb[0]) + 256 * int'(sb[1]);
    if (n > WORDS) begin
      exp_err = 1'b1;
      return;
    end
    for (int w = 0; w < n; w++) begin
      int base;
      base = 2 + 4 * w;
      if (fe >= 0 && fe < base + 4) begin
        exp_err = 1'b1;
        return;
      end
      if (base + 3 >= sb.size()) return;
      exp_addr.push_back(w[AW-1:0]);
      exp_data.push_back({sb[base+3], sb[base+2], sb[base+1], sb[base]});
    end
    exp_done = 1'b1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      repeat (CPB) @(negedge sysclk);
    end
  endtask

  task automatic do_reset();
    @(negedge sysclk);
    rst     = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge sysclk);
    chk("rst_addr",    64'(pmem_bus.pmem_wr_addr),   64'h0);
    chk("rst_data",    64'(pmem_bus.pmem_ram_in),    64'h0);
    chk("rst_wen",     64'(pmem_bus.pmem_byte_w_en), 64'h0);
    chk("rst_cpu_rst", 64'(cpu_rst), 64'h1);
    chk("rst_busy",    64'(busy),    64'h0);
    chk("rst_done",    64'(done),    64'h0);
    chk("rst_error",   64'(error),   64'h0);
    rst = 1'b1;
    repeat (2 * CPB) @(negedge sysclk);
  endtask

  task automatic run_case(input string name, input int fe, input bit glitch);
    int nw;
    do_reset();
    mon_addr.delete();
    mon_data.delete();
    last_strobe_cyc = -1;
    done_rise_cyc   = -1;
    build_expect(fe);
    if (glitch) begin
      uart_rx = 1'b0;
      @(negedge sysclk);
      uart_rx = 1'b1;
      repeat (4 * CPB) @(negedge sysclk);
    end
    for (int i = 0; i < sb.size(); i++) send_byte(sb[i], (i != fe));
    uart_rx = 1'b1;
    for (int k = 0; k < 20 * CPB && !(done === 1'b1 || error === 1'b1); k++)
      @(negedge sysclk);
    repeat (3) @(negedge sysclk);

    chk({name, ":nwr"}, 64'(mon_data.size()), 64'(exp_data.size()));
    nw = (mon_data.size() < exp_data.size()) ? mon_data.size() : exp_data.size();
    for (int i = 0; i < nw; i++) begin
      chk({name, ":addr"}, 64'(mon_addr[i]), 64'(exp_addr[i]));
      chk({name, ":data"}, 64'(mon_data[i]), 64'(exp_data[i]));
    end
    chk({name, ":done"},    64'(done),    64'(exp_done));
    chk({name, ":error"},   64'(error),   64'(exp_err));
    chk({name, ":cpu_rst"}, 64'(cpu_rst), 64'(!exp_done));
    chk({name, ":busy"},    64'(busy),    64'(!(exp_done || exp_err)));
    if (exp_done && exp_data.size() > 0)
      chk({name, ":done_lat"}, 64'(done_rise_cyc - last_strobe_cyc), 64'd1);
    $display("case %s: bytes=%0d fe=%0d writes=%0d/%0d done=%0b error=%0b",
             name, sb.size(), fe, mon_data.size(), exp_data.size(), done, error);
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < 4 * n; i++) sb.push_back(8'($urandom));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    sb = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    run_case("two_words", -1, 1'b0);

    sb = '{8'h00, 8'h00, 8'h55, 8'hAA, 8'h12};
    run_case("n_zero", -1, 1'b0);

    sb = '{8'h11, 8'h00, 8'h01, 8'h02};
    run_case("n_17", -1, 1'b0);

    sb = '{8'h10, 8'h00};
    push_words(16);
    run_case("n_16", -1, 1'b0);

    sb = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    run_case("stop_err", 4, 1'b0);

    sb = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_case("glitch", -1, 1'b1);

    // Partial load, then a reset (inside run_case) and a full resend
    sb = '{8'h01, 8'h00};
    push_words(1);
    do_reset();
    mon_data.delete();
    mon_addr.delete();
    for (int i = 0; i < 5; i++) send_byte(sb[i], 1'b1);
    repeat (2) @(negedge sysclk);
    chk("partial:busy",    64'(busy),    64'h1);
    chk("partial:cpu_rst", 64'(cpu_rst), 64'h1);
    chk("partial:done",    64'(done),    64'h0);
    chk("partial:nwr",     64'(mon_data.size()), 64'h0);
    run_case("reset_resend", -1, 1'b0);

    for (int t = 0; t < 8; t++) begin
      int n, fe;
      n  = $urandom_range(0, 18);
      sb = {};
      sb.push_back(8'(n));
      sb.push_back(8'h00);
      if (n <= WORDS) push_words(n);
      else push_words(1);
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) sb.push_back(8'($urandom));
      fe = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, sb.size() - 1)) : -1;
      run_case($sformatf("rand%0d", t), fe, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
